// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the fetch-stage PC sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [1:0]  CAUSE_ACCESS   = 2'b01;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'b10;
    localparam logic [31:0] INSN_BYTES     = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-memory fetch and decode hand-off bundle
interface pc_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata, imem_err,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata, imem_err,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );

endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch controller choosing the next PC and handing instructions to decode
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [31:0]           pc_cur,
    output logic                  pc_write,
    output logic [31:0]           pc_next,
    pc_sequencer_if.master        fbus,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_target,
    output logic                  trap_valid,
    output logic [1:0]            trap_cause,
    output logic [31:0]           trap_epc
);

    state_t      state, state_nxt;
    logic        kill, kill_nxt;
    logic [31:0] kill_tgt, kill_tgt_nxt;
    logic        if_valid_q;
    logic [31:0] if_instr_q, if_pc_q;
    logic        load;

    logic        wr_c, req_c, trap_c;
    logic [31:0] next_c, epc_c;
    logic [1:0]  cause_c;

    logic        misalign;
    logic [31:0] redir_addr;

    // A misaligned target never reaches the PC; the trap vector replaces it.
    assign misalign   = redirect_target[1:0] != 2'b00;
    assign redir_addr = misalign ? TRAP_VECTOR : redirect_target;

    always_comb begin
        state_nxt    = state;
        kill_nxt     = kill;
        kill_tgt_nxt = kill_tgt;
        load         = 1'b0;
        wr_c         = 1'b0;
        next_c       = 32'd0;
        req_c        = 1'b0;
        trap_c       = 1'b0;
        cause_c      = 2'b00;
        epc_c        = 32'd0;

        // Redirect handling shared by every state that honours it.
        if (state != ST_INIT && redirect_valid && misalign) begin
            trap_c  = 1'b1;
            cause_c = CAUSE_MISALIGN;
            epc_c   = redirect_target;
        end

        case (state)
            ST_INIT: begin
                wr_c      = 1'b1;
                next_c    = RESET_VECTOR;
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    wr_c      = 1'b1;
                    next_c    = redir_addr;
                    state_nxt = ST_FETCH;
                end else begin
                    req_c     = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid && fbus.imem_ack) begin
                    wr_c      = 1'b1;
                    next_c    = redir_addr;
                    kill_nxt  = 1'b0;
                    state_nxt = ST_FETCH;
                end else if (redirect_valid) begin
                    kill_nxt     = 1'b1;
                    kill_tgt_nxt = redir_addr;
                end else if (fbus.imem_ack) begin
                    state_nxt = ST_FETCH;
                    wr_c      = 1'b1;
                    if (kill) begin
                        next_c   = kill_tgt;
                        kill_nxt = 1'b0;
                    end else if (fbus.imem_err) begin
                        next_c  = TRAP_VECTOR;
                        trap_c  = 1'b1;
                        cause_c = CAUSE_ACCESS;
                        epc_c   = pc_cur;
                    end else begin
                        wr_c      = 1'b0;
                        load      = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    wr_c      = 1'b1;
                    next_c    = redir_addr;
                    state_nxt = ST_FETCH;
                end else if (fbus.if_ready) begin
                    wr_c      = 1'b1;
                    next_c    = pc_cur + INSN_BYTES;
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= ST_INIT;
            kill       <= 1'b0;
            kill_tgt   <= 32'd0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'd0;
            if_pc_q    <= 32'd0;
        end else begin
            state      <= state_nxt;
            kill       <= kill_nxt;
            kill_tgt   <= kill_tgt_nxt;
            if_valid_q <= state_nxt == ST_HOLD;
            if (load) begin
                if_instr_q <= fbus.imem_rdata;
                if_pc_q    <= pc_cur;
            end
        end
    end

    // Everything is forced quiet while reset is held.
    assign pc_write       = !res && wr_c;
    assign pc_next        = res ? 32'd0 : next_c;
    assign fbus.imem_req  = !res && req_c;
    assign fbus.imem_addr = res ? 32'd0 : pc_cur;
    assign trap_valid     = !res && trap_c;
    assign trap_cause     = res ? 2'b00 : cause_c;
    assign trap_epc       = res ? 32'd0 : epc_c;
    assign fbus.if_valid  = !res && if_valid_q;
    assign fbus.if_instr  = res ? 32'd0 : if_instr_q;
    assign fbus.if_pc     = res ? 32'd0 : if_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] pc_cur;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [1:0]  trap_cause;
    logic [31:0] trap_epc;
    int          passed = 0;
    int          total  = 0;

    pc_sequencer_if fb();

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_1000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk             (clk),
        .res             (res),
        .pc_cur          (pc_cur),
        .pc_write        (pc_write),
        .pc_next         (pc_next),
        .fbus            (fb),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_cause      (trap_cause),
        .trap_epc        (trap_epc)
    );

    always #5 clk = ~clk;

    // PC register that sits beside the sequencer in the fetch stage.
    always_ff @(posedge clk) begin
        if (res)
            pc_cur <= 32'd0;
        else if (pc_write)
            pc_cur <= pc_next;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        res = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0;
        fb.imem_ack = 1'b0; fb.imem_err = 1'b0; fb.imem_rdata = 32'd0; fb.if_ready = 1'b0;
        tick(); tick(); #1;
        total++;
        if ({pc_write, fb.imem_req, trap_valid, fb.if_valid} !== 4'b0000)
            $display("FAIL reset_ctl: got %b want 0000", {pc_write, fb.imem_req, trap_valid, fb.if_valid});
        else passed++;
        total++;
        if ({pc_next, fb.imem_addr, fb.if_instr, fb.if_pc} !== 128'd0)
            $display("FAIL reset_data: got %h want 0", {pc_next, fb.imem_addr, fb.if_instr, fb.if_pc});
        else passed++;
        tick(); res = 1'b0; #1;
        total++;
        if (pc_write !== 1'b1 || pc_next !== 32'h1000)
            $display("FAIL init_write: got %b/%h want 1/00001000", pc_write, pc_next);
        else passed++;
    endtask

    task automatic test_run();
        tick(); #1;
        total++;
        if (fb.imem_req !== 1'b1 || fb.imem_addr !== 32'h1000 || pc_write !== 1'b0)
            $display("FAIL run_req: got %b/%h/%b want 1/00001000/0", fb.imem_req, fb.imem_addr, pc_write);
        else passed++;
        tick(); fb.imem_ack = 1'b1; fb.imem_rdata = 32'h0000_0013; #1;
        total++;
        if (pc_write !== 1'b0 || fb.imem_req !== 1'b0 || fb.if_valid !== 1'b0)
            $display("FAIL run_wait: got %b/%b/%b want 0/0/0", pc_write, fb.imem_req, fb.if_valid);
        else passed++;
        tick(); fb.imem_ack = 1'b0; fb.imem_rdata = 32'hFFFF_FFFF; #1;
        total++;
        if (fb.if_valid !== 1'b1 || fb.if_instr !== 32'h13 || fb.if_pc !== 32'h1000)
            $display("FAIL run_hold: got %b/%h/%h want 1/00000013/00001000", fb.if_valid, fb.if_instr, fb.if_pc);
        else passed++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            total++;
            if (fb.if_valid !== 1'b1 || fb.if_instr !== 32'h13 || fb.imem_req !== 1'b0 || pc_write !== 1'b0)
                $display("FAIL bp_stall%0d: got %b/%h/%b/%b want 1/00000013/0/0",
                         i, fb.if_valid, fb.if_instr, fb.imem_req, pc_write);
            else passed++;
        end
        tick(); fb.if_ready = 1'b1; #1;
        total++;
        if (pc_write !== 1'b1 || pc_next !== 32'h1004)
            $display("FAIL bp_release: got %b/%h want 1/00001004", pc_write, pc_next);
        else passed++;
        tick(); fb.if_ready = 1'b0; #1;
        total++;
        if (fb.imem_req !== 1'b1 || fb.imem_addr !== 32'h1004 || fb.if_valid !== 1'b0)
            $display("FAIL bp_next: got %b/%h/%b want 1/00001004/0", fb.imem_req, fb.imem_addr, fb.if_valid);
        else passed++;
        tick(); fb.imem_ack = 1'b1; fb.imem_rdata = 32'h0010_0093;
        tick(); fb.imem_ack = 1'b0; #1;
        total++;
        if (fb.if_valid !== 1'b1 || fb.if_instr !== 32'h0010_0093 || fb.if_pc !== 32'h1004)
            $display("FAIL bp_second: got %b/%h/%h want 1/00100093/00001004", fb.if_valid, fb.if_instr, fb.if_pc);
        else passed++;
    endtask

    task automatic test_redirect_hold();
        fb.if_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h2000; #1;
        total++;
        if (pc_write !== 1'b1 || pc_next !== 32'h2000 || trap_valid !== 1'b0)
            $display("FAIL redir_hold: got %b/%h/%b want 1/00002000/0", pc_write, pc_next, trap_valid);
        else passed++;
        tick(); redirect_valid = 1'b0; fb.if_ready = 1'b0; #1;
        total++;
        if (fb.if_valid !== 1'b0 || fb.imem_req !== 1'b1 || fb.imem_addr !== 32'h2000)
            $display("FAIL redir_hold_next: got %b/%b/%h want 0/1/00002000", fb.if_valid, fb.imem_req, fb.imem_addr);
        else passed++;
    endtask

    task automatic test_redirect_wait();
        tick(); redirect_valid = 1'b1; redirect_target = 32'h2800; #1;
        total++;
        if (pc_write !== 1'b0)
            $display("FAIL redir_wait_defer: got %b want 0", pc_write);
        else passed++;
        tick(); redirect_target = 32'h3000;
        tick(); redirect_valid = 1'b0;
        tick(); fb.imem_ack = 1'b1; fb.imem_rdata = 32'hDEAD_BEEF; #1;
        total++;
        if (pc_write !== 1'b1 || pc_next !== 32'h3000)
            $display("FAIL redir_wait_ack: got %b/%h want 1/00003000", pc_write, pc_next);
        else passed++;
        tick(); fb.imem_ack = 1'b0; #1;
        total++;
        if (fb.if_valid !== 1'b0 || fb.imem_req !== 1'b1 || fb.imem_addr !== 32'h3000)
            $display("FAIL redir_wait_next: got %b/%b/%h want 0/1/00003000", fb.if_valid, fb.imem_req, fb.imem_addr);
        else passed++;
        tick(); fb.imem_ack = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1008; #1;
        total++;
        if (pc_write !== 1'b1 || pc_next !== 32'h1008)
            $display("FAIL redir_ack_same: got %b/%h want 1/00001008", pc_write, pc_next);
        else passed++;
        tick(); fb.imem_ack = 1'b0; redirect_valid = 1'b0; #1;
        total++;
        if (fb.if_valid !== 1'b0 || fb.imem_addr !== 32'h1008 || fb.imem_req !== 1'b1)
            $display("FAIL redir_ack_next: got %b/%h/%b want 0/00001008/1", fb.if_valid, fb.imem_addr, fb.imem_req);
        else passed++;
    endtask

    task automatic test_access_error();
        tick(); fb.imem_ack = 1'b1; fb.imem_err = 1'b1; #1;
        total++;
        if (trap_valid !== 1'b1 || trap_cause !== 2'b01 || trap_epc !== 32'h1008)
            $display("FAIL err_trap: got %b/%b/%h want 1/01/00001008", trap_valid, trap_cause, trap_epc);
        else passed++;
        total++;
        if (pc_write !== 1'b1 || pc_next !== 32'h100)
            $display("FAIL err_vector: got %b/%h want 1/00000100", pc_write, pc_next);
        else passed++;
        tick(); fb.imem_ack = 1'b0; fb.imem_err = 1'b0; #1;
        total++;
        if (trap_valid !== 1'b0 || fb.imem_addr !== 32'h100 || fb.imem_req !== 1'b1)
            $display("FAIL err_next: got %b/%h/%b want 0/00000100/1", trap_valid, fb.imem_addr, fb.imem_req);
        else passed++;
        tick(); fb.imem_ack = 1'b1; fb.imem_err = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h4000; #1;
        total++;
        if (trap_valid !== 1'b0 || pc_write !== 1'b1 || pc_next !== 32'h4000)
            $display("FAIL err_redir: got %b/%b/%h want 0/1/00004000", trap_valid, pc_write, pc_next);
        else passed++;
        tick(); fb.imem_ack = 1'b0; fb.imem_err = 1'b0; redirect_valid = 1'b0; #1;
        total++;
        if (fb.imem_addr !== 32'h4000 || fb.imem_req !== 1'b1)
            $display("FAIL err_redir_next: got %h/%b want 00004000/1", fb.imem_addr, fb.imem_req);
        else passed++;
    endtask

    task automatic test_misalign();
        tick(); fb.imem_ack = 1'b1; fb.imem_rdata = 32'h0000_0033;
        tick(); fb.imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h2002; #1;
        total++;
        if (trap_valid !== 1'b1 || trap_cause !== 2'b10 || trap_epc !== 32'h2002)
            $display("FAIL mis_trap: got %b/%b/%h want 1/10/00002002", trap_valid, trap_cause, trap_epc);
        else passed++;
        total++;
        if (pc_write !== 1'b1 || pc_next !== 32'h100)
            $display("FAIL mis_vector: got %b/%h want 1/00000100", pc_write, pc_next);
        else passed++;
        tick(); redirect_valid = 1'b0; #1;
        total++;
        if (trap_valid !== 1'b0 || fb.imem_addr !== 32'h100 || fb.if_valid !== 1'b0)
            $display("FAIL mis_next: got %b/%h/%b want 0/00000100/0", trap_valid, fb.imem_addr, fb.if_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        tick(); res = 1'b1; #1;
        total++;
        if ({pc_write, fb.imem_req, trap_valid, fb.imem_addr} !== 35'd0)
            $display("FAIL rst_wait_quiet: got %h want 0", {pc_write, fb.imem_req, trap_valid, fb.imem_addr});
        else passed++;
        tick(); res = 1'b0; fb.imem_ack = 1'b1; fb.imem_rdata = 32'hBAD0_BAD0; #1;
        total++;
        if (pc_write !== 1'b1 || pc_next !== 32'h1000 || trap_valid !== 1'b0)
            $display("FAIL rst_init_ack: got %b/%h/%b want 1/00001000/0", pc_write, pc_next, trap_valid);
        else passed++;
        tick(); fb.imem_ack = 1'b0; #1;
        total++;
        if (fb.if_valid !== 1'b0 || fb.if_instr !== 32'd0 || fb.imem_addr !== 32'h1000 || fb.imem_req !== 1'b1)
            $display("FAIL rst_restart: got %b/%h/%h/%b want 0/00000000/00001000/1",
                     fb.if_valid, fb.if_instr, fb.imem_addr, fb.imem_req);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_backpressure();
        test_redirect_hold();
        test_redirect_wait();
        test_access_error();
        test_misalign();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that sequences the 32-bit program counter register and the instruction-memory fetch handshake. It decides when the PC is written and with what value: reset vector, sequential +4, branch/jump redirect, or trap vector. It hands fetched instructions to decode over a valid/ready interface. The block sits between the PC register, instruction memory and the decode stage.

## Interface
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100: fetch address after any fetch trap.
- clk  in  1  clock; all state changes on rising edge.
- res  in  1  synchronous, active-high reset.
- pc_cur  in  32  current PC register value.
- pc_write  out  1  PC register write enable.
- pc_next  out  32  PC register write data.
- imem_req  out  1  fetch request, one-cycle pulse.
- imem_addr  out  32  fetch address; equals pc_cur.
- imem_ack  in  1  fetch response valid.
- imem_rdata  in  32  fetched instruction word.
- imem_err  in  1  fetch access error; qualified by imem_ack.
- if_valid  out  1  instruction available to decode.
- if_instr  out  32  latched instruction.
- if_pc  out  32  address of if_instr.
- if_ready  in  1  decode accepts instruction.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  32  new PC.
- trap_valid  out  1  one-cycle fetch-trap pulse.
- trap_cause  out  2  01 access error, 10 misaligned target.
- trap_epc  out  32  faulting fetch address or redirect target.

## Operation
- States: INIT, FETCH, WAIT, HOLD.
- INIT: pc_write=1, pc_next=RESET_VECTOR; next state FETCH.
- FETCH: imem_req=1; next state WAIT.
- WAIT, ack without error and no kill pending:
  - Latch imem_rdata into if_instr and pc_cur into if_pc.
  - Next state HOLD.
- WAIT, ack with error:
  - trap_valid=1, cause 01, epc=pc_cur.
  - pc_write TRAP_VECTOR; next state FETCH.
- HOLD: if_valid=1. On if_ready: pc_write=1, pc_next=pc_cur+4 (wraps modulo 2^32); next state FETCH.
- Redirect, any state except INIT:
  - Redirect wins over the decode handshake and over imem_err.
  - If target[1:0]≠0: trap cause 10, epc=target, and TRAP_VECTOR is used in place of the target.
- Redirect in FETCH or HOLD:
  - Write the target (or TRAP_VECTOR) at once; next state FETCH.
  - In FETCH, imem_req is suppressed. In HOLD, the held instruction is dropped and if_valid is deasserted.
- Redirect in WAIT:
  - Latch the target and set kill.
  - A later redirect overwrites the latched target.
  - On ack, the data and error are discarded; write the latched target; next state FETCH.
  - If redirect and ack arrive in the same cycle, act immediately on the redirect.
- imem_ack outside WAIT is ignored.
- Exactly one request is outstanding at any time.

## Timing
- pc_write, pc_next, imem_req, trap_* are combinational from state and inputs. The PC updates on the edge that ends the cycle.
- if_valid, if_instr and if_pc are registered.
- Reset values:
  - State INIT, kill=0.
  - if_instr=0, if_pc=0.
  - if_valid=0, imem_req=0, pc_write=0, trap_valid=0.
- While res is high, all outputs are 0.
- INIT occupies the first cycle after res falls.
- Latency: ack in cycle N gives if_valid in cycle N+1.
- Minimum 3 cycles per instruction (FETCH, WAIT, HOLD).
- res mid-WAIT abandons the request. A stale ack arriving afterwards is ignored because it is outside WAIT.

## Structure
- Shared package pc_seq_pkg holds:
  - State enum.
  - Trap cause constants CAUSE_ACCESS=2'b01 and CAUSE_MISALIGN=2'b10.
  - INSN_BYTES=4.
- No sub-module. The existing PC register is instantiated beside this block in the parent fetch stage, sharing clk and res.

## Test plan
- Reset and run: RESET_VECTOR=0x1000, ack 1 cycle after each req, rdata 0x00000013, if_ready=1 → pc_write 0x1000 in INIT; if_valid with instr 0x13, if_pc 0x1000; next imem_addr 0x1004.
- Backpressure: if_ready=0 for 5 cycles in HOLD → if_valid stays high, if_instr stable, no imem_req, no pc_write. Then if_ready=1 → pc_next=if_pc+4.
- Redirect in HOLD to 0x2000 → no handshake completes, pc_write 0x2000 same cycle, next imem_addr 0x2000.
- Redirect in WAIT to 0x3000, ack 3 cycles later with 0xDEADBEEF → no if_valid, pc_write 0x3000 in the ack cycle.
- imem_err at 0x1008 → trap_valid for 1 cycle, cause 01, epc 0x1008, next fetch 0x100. Same with a simultaneous redirect to 0x4000 → no trap, fetch 0x4000.
- Misaligned redirect to 0x2002 → trap cause 10, epc 0x2002, fetch 0x100. Then res asserted mid-WAIT with ack arriving during INIT → ack ignored, fetch restarts at RESET_VECTOR.
